fp32_addsub_norm: RTL and testbench

- Elastic pipelined stage directly downstream of the single-precision alignment stage.
- Consumes the two aligned 24-bit mantissas (hidden bit included), the common exponent, the sticky bit and the exception flag.
- Performs the effective add/subtract, then leading-zero normalization.
- Hands a normalized mantissa, exponent, sign, round bit and sticky bit to the rounding/pack stage.

---
 rtl/fp32_addsub_norm.sv | 139 +++++++++++++
 tb/tb_fp32_addsub_norm.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_addsub_norm.sv
// fp32_addsub_norm: elastic add/subtract and leading-zero normalization stage for single precision
module fp32_addsub_norm #(
  parameter bit NORM_REG = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_op,
  input  logic        in_sign_a,
  input  logic        in_sign_b,
  input  logic [23:0] in_mant_a,
  input  logic [23:0] in_mant_b,
  input  logic [7:0]  in_exp,
  input  logic        in_sticky,
  input  logic        in_exception,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [7:0]  out_exp,
  output logic [22:0] out_mant,
  output logic        out_round,
  output logic        out_sticky,
  output logic        out_zero,
  output logic        out_overflow,
  output logic        out_exception
);
  logic        eb, same, a_ge_b, a_zero, a_sign;
  logic [24:0] a_sum;
  logic        s1_valid, s1_sign, s1_sticky, s1_exc, s1_zero, s1_advance;
  logic [24:0] s1_sum;
  logic [7:0]  s1_exp;
  logic [4:0]  lz;
  logic [7:0]  e1, em1, sh, ec;
  logic [23:0] r, m;
  logic        n_sign, n_round, n_sticky, n_zero, n_ovf, n_exc;
  logic [7:0]  n_exp;
  logic [22:0] n_mant;

  assign eb     = in_sign_b ^ in_op;
  assign same   = in_sign_a == eb;
  assign a_ge_b = in_mant_a >= in_mant_b;
  assign a_sum  = same ? {1'b0, in_mant_a} + {1'b0, in_mant_b}
                : a_ge_b ? {1'b0, in_mant_a - in_mant_b} : {1'b0, in_mant_b - in_mant_a};
  assign a_zero = ~in_exception & ~in_sticky & (a_sum == 25'd0);
  assign a_sign = ~a_zero & ((same | a_ge_b) ? in_sign_a : eb);
  assign in_ready = ~s1_valid | s1_advance;

  // Stage 1: capture the signed magnitude result whenever the slot is free or draining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_sum    <= 25'd0;
      s1_exp    <= 8'd0;
      s1_sticky <= 1'b0;
      s1_exc    <= 1'b0;
      s1_zero   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign   <= a_sign;
        s1_sum    <= a_sum;
        s1_exp    <= in_exp;
        s1_sticky <= in_sticky;
        s1_exc    <= in_exception;
        s1_zero   <= a_zero;
      end
    end
  end

  // Leading-zero count of the uncarried 24-bit result
  always_comb begin
    lz = 5'd24;
    for (int i = 0; i < 24; i++) if (r[i]) lz = 5'(23 - i);
  end

  assign r   = s1_sum[23:0];
  assign e1  = (s1_exp == 8'd0) ? 8'd1 : s1_exp;
  assign em1 = e1 - 8'd1;
  assign sh  = ({3'b0, lz} < em1) ? {3'b0, lz} : em1;
  assign m   = r << sh;
  assign ec  = e1 + 8'd1;

  // Normalization; exceptions and exact zeros override the arithmetic result
  always_comb begin
    n_exc    = s1_exc;
    n_zero   = ~s1_exc & s1_zero;
    n_ovf    = ~s1_exc & ~s1_zero & s1_sum[24] & (e1 == 8'd254);
    n_sign   = ~s1_exc & s1_sign;
    n_round  = ~s1_exc & ~s1_zero & s1_sum[24] & s1_sum[0];
    n_sticky = ~s1_exc & s1_sticky;
    n_exp    = (s1_exc | n_ovf) ? 8'hff : s1_zero ? 8'd0 : s1_sum[24] ? ec : m[23] ? e1 - sh : 8'd0;
    n_mant   = (s1_exc | n_ovf | s1_zero) ? 23'd0 : s1_sum[24] ? s1_sum[23:1] : m[22:0];
  end

  if (NORM_REG) begin : g_reg
    logic s2_valid;
    assign s1_advance = s1_valid & (~s2_valid | out_ready);
    assign out_valid  = s2_valid;
    // Stage 2: register the normalized result, holding it while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid      <= 1'b0;
        out_sign      <= 1'b0;
        out_exp       <= 8'd0;
        out_mant      <= 23'd0;
        out_round     <= 1'b0;
        out_sticky    <= 1'b0;
        out_zero      <= 1'b0;
        out_overflow  <= 1'b0;
        out_exception <= 1'b0;
      end else if (~s2_valid | out_ready) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_sign      <= n_sign;
          out_exp       <= n_exp;
          out_mant      <= n_mant;
          out_round     <= n_round;
          out_sticky    <= n_sticky;
          out_zero      <= n_zero;
          out_overflow  <= n_ovf;
          out_exception <= n_exc;
        end
      end
    end
  end else begin : g_comb
    assign s1_advance    = s1_valid & out_ready;
    assign out_valid     = s1_valid;
    assign out_sign      = n_sign;
    assign out_exp       = n_exp;
    assign out_mant      = n_mant;
    assign out_round     = n_round;
    assign out_sticky    = n_sticky;
    assign out_zero      = n_zero;
    assign out_overflow  = n_ovf;
    assign out_exception = n_exc;
  end
endmodule

// File: tb/tb_fp32_addsub_norm.sv
// tb_fp32_addsub_norm: directed and randomized checks of the add/normalize stage against an arithmetic model
module tb_fp32_addsub_norm;
  typedef struct packed {
    logic        op, sa, sb;
    logic [23:0] a, b;
    logic [7:0]  e;
    logic        st, ex;
  } beat_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_op, in_sign_a, in_sign_b, in_sticky, in_exception;
  logic [23:0] in_mant_a, in_mant_b;
  logic [7:0]  in_exp;
  logic        out_valid, out_ready = 1'b1, out_sign, out_round, out_sticky, out_zero, out_overflow, out_exception;
  logic [7:0]  out_exp;
  logic [22:0] out_mant;
  logic [36:0] outs;
  int          passed = 0, failed = 0, total = 0;
  logic [36:0] q[$];
  beat_t       cur, bp[4];
  int          idx, lat, guard;
  logic        acc;

  fp32_addsub_norm dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_sign_a(in_sign_a), .in_sign_b(in_sign_b), .in_mant_a(in_mant_a), .in_mant_b(in_mant_b),
    .in_exp(in_exp), .in_sticky(in_sticky), .in_exception(in_exception), .out_valid(out_valid),
    .out_ready(out_ready), .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant),
    .out_round(out_round), .out_sticky(out_sticky), .out_zero(out_zero),
    .out_overflow(out_overflow), .out_exception(out_exception)
  );

  assign outs = {out_sign, out_exp, out_mant, out_round, out_sticky, out_zero, out_overflow, out_exception};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic drive(input beat_t x);
    in_op = x.op; in_sign_a = x.sa; in_sign_b = x.sb; in_mant_a = x.a; in_mant_b = x.b;
    in_exp = x.e; in_sticky = x.st; in_exception = x.ex;
  endtask

  // Result fields: {sign, exp, mant, round, sticky, zero, overflow, exception}
  function automatic logic [36:0] model(input beat_t x);
    int   r, mag, ee, mm;
    logic sg;
    if (x.ex) return {1'b0, 8'hff, 23'd0, 5'b00001};
    r = (x.sa ? -int'(x.a) : int'(x.a)) + ((x.sb ^ x.op) ? -int'(x.b) : int'(x.b));
    mag = (r < 0) ? -r : r;
    if (mag == 0 && !x.st) return {1'b0, 8'd0, 23'd0, 5'b00100};
    sg = (r == 0) ? x.sa : (r < 0);
    ee = (x.e == 8'd0) ? 1 : int'(x.e);
    if (mag >= (1 << 24)) begin
      ee++;
      if (ee == 255) return {sg, 8'hff, 23'd0, mag[0], x.st, 1'b0, 1'b1, 1'b0};
      return {sg, 8'(ee), 23'(mag >> 1), mag[0], x.st, 3'b000};
    end
    mm = mag;
    while (mm < (1 << 23) && ee > 1) begin
      mm = mm << 1;
      ee--;
    end
    if (mm < (1 << 23)) ee = 0;
    return {sg, 8'(ee), 23'(mm), 1'b0, x.st, 3'b000};
  endfunction

  function automatic beat_t rand_beat();
    beat_t x;
    x.op = 1'($urandom); x.sa = 1'($urandom); x.sb = 1'($urandom);
    x.a  = 24'($urandom) | 24'h800000;
    x.b  = (24'($urandom) | 24'h800000) >> $urandom_range(0, 25);
    if ($urandom_range(0, 7) == 0) x.b = x.a;
    if ($urandom_range(0, 1) == 0) {x.a, x.b} = {x.b, x.a};
    x.e  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(200, 254));
    x.st = ($urandom_range(0, 3) == 0);
    x.ex = ($urandom_range(0, 15) == 0);
    return x;
  endfunction

  task automatic send_check(input string tag, input beat_t x, input logic [36:0] want);
    @(posedge clk); #1;
    drive(x);
    in_valid = 1'b1;
    @(negedge clk);
    chk({tag, " in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, 2);
    chk({tag, " result"}, outs, want);
  endtask

  initial begin
    drive('0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset outputs", outs, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    send_check("carry", '{1'b0, 1'b0, 1'b0, 24'h800000, 24'h800000, 8'd127, 1'b0, 1'b0},
               {1'b0, 8'd128, 23'd0, 5'b00000});
    send_check("sub_norm", '{1'b1, 1'b0, 1'b0, 24'h800000, 24'h600000, 8'd127, 1'b0, 1'b0},
               {1'b0, 8'd125, 23'd0, 5'b00000});
    send_check("cancel", '{1'b1, 1'b0, 1'b0, 24'hC00000, 24'hC00000, 8'd130, 1'b0, 1'b0},
               {1'b0, 8'd0, 23'd0, 5'b00100});
    send_check("overflow", '{1'b0, 1'b0, 1'b0, 24'hFFFFFF, 24'hFFFFFF, 8'd254, 1'b0, 1'b0},
               {1'b0, 8'hff, 23'd0, 5'b00010});
    send_check("denormal", '{1'b0, 1'b0, 1'b0, 24'h400000, 24'h000000, 8'd1, 1'b0, 1'b0},
               {1'b0, 8'd0, 23'h400000, 5'b00000});
    send_check("exception", '{1'b0, 1'b1, 1'b0, 24'h812345, 24'h400000, 8'd90, 1'b1, 1'b1},
               {1'b0, 8'hff, 23'd0, 5'b00001});

    bp[0] = '{1'b0, 1'b0, 1'b0, 24'h800000, 24'h800000, 8'd127, 1'b0, 1'b0};
    bp[1] = '{1'b0, 1'b0, 1'b1, 24'h900000, 24'h100000, 8'd40, 1'b0, 1'b1};
    bp[2] = '{1'b1, 1'b1, 1'b0, 24'h800000, 24'h600000, 8'd127, 1'b1, 1'b0};
    bp[3] = '{1'b1, 1'b0, 1'b0, 24'h123456, 24'h923456, 8'd20, 1'b0, 1'b0};
    @(posedge clk); #1;
    out_ready = 1'b0;
    idx = 0;
    q.delete();
    for (int c = 0; c < 4; c++) begin
      drive(bp[idx]);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(bp[idx]));
        idx++;
      end
      @(posedge clk); #1;
    end
    chk("bp captured", idx, 2);
    chk("bp in_ready low", in_ready, 0);
    chk("bp held data", outs, q[0]);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (idx < 4) drive(bp[idx]);
      in_valid = (idx < 4);
      @(negedge clk);
      chk("bp out_valid", out_valid, 1);
      if (q.size() > 0) chk("bp order", outs, q.pop_front());
      if (in_valid && in_ready) begin
        q.push_back(model(bp[idx]));
        idx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp all accepted", idx, 4);
    chk("bp none pending", q.size(), 0);

    out_ready = 1'b0;
    drive(bp[1]);
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("pre-reset valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset valid", out_valid, 0);
    chk("async reset data", outs, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post-reset quiet", out_valid, 0);
    end

    q.delete();
    acc = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        cur = rand_beat();
        drive(cur);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (q.size() > 0) chk("rnd data", outs, q.pop_front());
        else chk("rnd spurious", out_valid, 0);
      end
      acc = in_valid && in_ready;
      if (acc) q.push_back(model(cur));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(negedge clk);
      if (out_valid) chk("drain data", outs, q.pop_front());
      @(posedge clk); #1;
      guard++;
    end
    chk("drain complete", q.size(), 0);
    @(negedge clk);
    chk("idle after drain", out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
